// File: rtl/lc3b_types.sv
// LC-3b shared types: opcode encoding, data word, condition-code vector and
// the redirect latch record used by the branch resolve unit.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_nzp;   // {n,z,p}

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  localparam lc3b_nzp CC_RESET = 3'b010;

  // Pending fetch redirect.
  typedef struct packed {
    logic     vld;
    lc3b_word pc;
  } redirect_t;

endpackage

// File: rtl/cc_gen.sv
// Condition-code generator: maps a 16-bit result onto {n,z,p}.
// Purely combinational; shared with the forwarding unit.
//   data : value being written back
//   cc   : 100 negative, 010 zero, 001 positive
module cc_gen
  import lc3b_types::*;
(
  input  lc3b_word data,
  output lc3b_nzp  cc
);

  assign cc = data[15]         ? 3'b100 :
              (data == 16'h0)  ? 3'b010 : 3'b001;

endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage control-flow resolution for the LC-3b pipeline.
//   Inputs : clk, rst_n (sync, active low), stall, valid_in, opcode, nzp,
//            br_target / jmp_target / trap_target, wb_data + load_cc (CC
//            write from WB), fetch_ready (fetch takes redirect), perf_clear.
//   Outputs: branch_enable, is_j, is_jsr, is_trap (combinational decode for
//            the flush controller), redirect_valid / redirect_pc (latched
//            target), cc (architectural CC), branch_count / taken_count.
module branch_resolve_unit
  import lc3b_types::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 valid_in,
  input  lc3b_opcode           opcode,
  input  lc3b_nzp              nzp,
  input  lc3b_word             br_target,
  input  lc3b_word             jmp_target,
  input  lc3b_word             trap_target,
  input  lc3b_word             wb_data,
  input  logic                 load_cc,
  input  logic                 fetch_ready,
  input  logic                 perf_clear,
  output logic                 branch_enable,
  output logic                 is_j,
  output logic                 is_jsr,
  output logic                 is_trap,
  output logic                 redirect_valid,
  output lc3b_word             redirect_pc,
  output lc3b_nzp              cc,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] taken_count
);

  lc3b_nzp              cc_q, wb_cc, cc_eff;
  redirect_t            rdr_q;
  lc3b_word             tgt_sel;
  logic [CNT_WIDTH-1:0] bcnt_q, tcnt_q;
  logic                 is_br, resolve, accept, count_br;

  cc_gen u_cc_gen (.data(wb_data), .cc(wb_cc));

  // WB writes CC in the same cycle a BR sits in MEM: evaluate against the
  // incoming value rather than the stale register.
  assign cc_eff = load_cc ? wb_cc : cc_q;

  // Decode is left ungated by stall; the flush controller qualifies it.
  assign is_br         = valid_in & (opcode == op_br);
  assign branch_enable = is_br & |(nzp & cc_eff);
  assign is_j          = valid_in & (opcode == op_jmp);
  assign is_jsr        = valid_in & (opcode == op_jsr);
  assign is_trap       = valid_in & (opcode == op_trap);

  assign resolve = branch_enable | is_j | is_jsr | is_trap;
  // Anything resolving while a redirect is still outstanding is wrong-path.
  assign accept   = ~stall & ~rdr_q.vld & resolve;
  assign count_br = ~stall & ~rdr_q.vld & is_br;

  always_comb begin
    tgt_sel = br_target;
    if (is_trap)              tgt_sel = trap_target;
    else if (is_j | is_jsr)   tgt_sel = jmp_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cc_q   <= CC_RESET;
      rdr_q  <= '0;
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (load_cc & ~stall) cc_q <= wb_cc;

      // accept requires no pending redirect, so the two arms never collide.
      // Fetch drains the latch regardless of back-end stall.
      if (accept) begin
        rdr_q.vld <= 1'b1;
        rdr_q.pc  <= tgt_sel;
      end else if (rdr_q.vld & fetch_ready) begin
        rdr_q.vld <= 1'b0;
      end

      if (perf_clear) begin
        bcnt_q <= '0;
        tcnt_q <= '0;
      end else if (count_br) begin
        bcnt_q <= bcnt_q + CNT_WIDTH'(1);
        if (branch_enable) tcnt_q <= tcnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign redirect_valid = rdr_q.vld;
  assign redirect_pc    = rdr_q.pc;
  assign cc             = cc_q;
  assign branch_count   = bcnt_q;
  assign taken_count    = tcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Two instances share stimulus: one
// with 16-bit counters and one with 4-bit counters to exercise wrap.
module tb_branch_resolve_unit;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, stall, valid_in, load_cc, fetch_ready, perf_clear;
  lc3b_opcode opcode;
  lc3b_nzp    nzp;
  lc3b_word   br_target, jmp_target, trap_target, wb_data;

  logic       be16, j16, jsr16, tr16, rv16;
  lc3b_word   rpc16;
  lc3b_nzp    cc16;
  logic [15:0] bc16, tc16;

  logic       be4, j4, jsr4, tr4, rv4;
  lc3b_word   rpc4;
  lc3b_nzp    cc4;
  logic [3:0] bc4, tc4;

  branch_resolve_unit #(.CNT_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .valid_in(valid_in),
    .opcode(opcode), .nzp(nzp), .br_target(br_target), .jmp_target(jmp_target),
    .trap_target(trap_target), .wb_data(wb_data), .load_cc(load_cc),
    .fetch_ready(fetch_ready), .perf_clear(perf_clear),
    .branch_enable(be16), .is_j(j16), .is_jsr(jsr16), .is_trap(tr16),
    .redirect_valid(rv16), .redirect_pc(rpc16), .cc(cc16),
    .branch_count(bc16), .taken_count(tc16));

  branch_resolve_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .valid_in(valid_in),
    .opcode(opcode), .nzp(nzp), .br_target(br_target), .jmp_target(jmp_target),
    .trap_target(trap_target), .wb_data(wb_data), .load_cc(load_cc),
    .fetch_ready(fetch_ready), .perf_clear(perf_clear),
    .branch_enable(be4), .is_j(j4), .is_jsr(jsr4), .is_trap(tr4),
    .redirect_valid(rv4), .redirect_pc(rpc4), .cc(cc4),
    .branch_count(bc4), .taken_count(tc4));

  typedef struct {
    logic        be, j, jsr, tr, rv;
    logic [15:0] rpc;
    logic [2:0]  cc;
    int          bc, tc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   step     = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    step++;
  endtask

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; valid_in = 1'b0; load_cc = 1'b0;
    fetch_ready = 1'b0; perf_clear = 1'b0; opcode = op_add; nzp = 3'b000;
    wb_data = 16'h0;
  endtask

  task automatic push(logic be, logic j, logic jsr, logic tr, logic rv,
                      logic [15:0] rpc, logic [2:0] c, int bc, int tc);
    exp_t e;
    e.be = be; e.j = j; e.jsr = jsr; e.tr = tr; e.rv = rv;
    e.rpc = rpc; e.cc = c; e.bc = bc; e.tc = tc;
    sb.push_back(e);
  endtask

  task automatic ck(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, step, obs, exp);
    end
  endtask

  // Pop the expectation for this cycle and compare it with both instances.
  task automatic check();
    exp_t e;
    #1;
    e = sb.pop_front();
    ck("branch_enable", 32'(be16),  32'(e.be));
    ck("is_j",          32'(j16),   32'(e.j));
    ck("is_jsr",        32'(jsr16), 32'(e.jsr));
    ck("is_trap",       32'(tr16),  32'(e.tr));
    ck("redirect_valid",32'(rv16),  32'(e.rv));
    ck("redirect_pc",   32'(rpc16), 32'(e.rpc));
    ck("cc",            32'(cc16),  32'(e.cc));
    ck("branch_count",  32'(bc16),  e.bc & 32'hFFFF);
    ck("taken_count",   32'(tc16),  e.tc & 32'hFFFF);
    ck("w4_redirect",   32'(rv4),   32'(e.rv));
    ck("w4_branch_cnt", 32'(bc4),   e.bc & 32'hF);
    ck("w4_taken_cnt",  32'(tc4),   e.tc & 32'hF);
  endtask

  initial begin
    idle();
    br_target = 16'h0; jmp_target = 16'h0; trap_target = 16'h0;
    rst_n = 1'b0;
    tick(); tick();
    // reset state
    idle(); rst_n = 1'b0;
    push(0,0,0,0, 0,16'h0000,3'b010, 0,0); check();
    // BRz taken from reset CC
    tick(); idle(); valid_in = 1; opcode = op_br; nzp = 3'b010; br_target = 16'h1234;
    push(1,0,0,0, 0,16'h0000,3'b010, 0,0); check();
    tick(); idle(); fetch_ready = 1;
    push(0,0,0,0, 1,16'h1234,3'b010, 1,1); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h1234,3'b010, 1,1); check();
    // perf_clear
    tick(); idle(); perf_clear = 1;
    push(0,0,0,0, 0,16'h1234,3'b010, 1,1); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h1234,3'b010, 0,0); check();
    // BRp with WB writing a negative value: bypass says n -> not taken
    tick(); idle(); valid_in = 1; opcode = op_br; nzp = 3'b001; br_target = 16'h2222;
    load_cc = 1; wb_data = 16'h8000;
    push(0,0,0,0, 0,16'h1234,3'b010, 0,0); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h1234,3'b100, 1,0); check();
    // BRp while cc_q=n but WB writes positive: bypass makes it taken
    tick(); idle(); valid_in = 1; opcode = op_br; nzp = 3'b001; br_target = 16'h4444;
    load_cc = 1; wb_data = 16'h0007;
    push(1,0,0,0, 0,16'h1234,3'b100, 1,0); check();
    tick(); idle(); fetch_ready = 1;
    push(0,0,0,0, 1,16'h4444,3'b001, 2,1); check();
    // JMP, fetch not ready for 3 cycles
    tick(); idle(); valid_in = 1; opcode = op_jmp; jmp_target = 16'h3000;
    push(0,1,0,0, 0,16'h4444,3'b001, 2,1); check();
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
      push(0,0,0,0, 1,16'h3000,3'b001, 2,1); check();
    end
    tick(); idle(); fetch_ready = 1;
    push(0,0,0,0, 1,16'h3000,3'b001, 2,1); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h3000,3'b001, 2,1); check();
    // taken BR held under stall for 2 cycles
    for (int i = 0; i < 3; i++) begin
      tick(); idle(); valid_in = 1; opcode = op_br; nzp = 3'b111; br_target = 16'h5555;
      stall = (i < 2);
      push(1,0,0,0, 0,16'h3000,3'b001, 2,1); check();
    end
    tick(); idle(); fetch_ready = 1;
    push(0,0,0,0, 1,16'h5555,3'b001, 3,2); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h5555,3'b001, 3,2); check();
    // JSR
    tick(); idle(); valid_in = 1; opcode = op_jsr; jmp_target = 16'h0600;
    push(0,0,1,0, 0,16'h5555,3'b001, 3,2); check();
    tick(); idle(); fetch_ready = 1;
    push(0,0,0,0, 1,16'h0600,3'b001, 3,2); check();
    // TRAP, then a BR 111 while pending: blocked even though fetch_ready=1
    tick(); idle(); valid_in = 1; opcode = op_trap; trap_target = 16'h0400;
    push(0,0,0,1, 0,16'h0600,3'b001, 3,2); check();
    tick(); idle(); valid_in = 1; opcode = op_br; nzp = 3'b111; br_target = 16'h7777;
    fetch_ready = 1;
    push(1,0,0,0, 1,16'h0400,3'b001, 3,2); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h0400,3'b001, 3,2); check();
    // load_cc under stall leaves cc untouched
    tick(); idle(); load_cc = 1; wb_data = 16'h0000; stall = 1;
    push(0,0,0,0, 0,16'h0400,3'b001, 3,2); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h0400,3'b001, 3,2); check();
    // fetch_ready drains the latch even while stalled
    tick(); idle(); valid_in = 1; opcode = op_jmp; jmp_target = 16'h1000;
    push(0,1,0,0, 0,16'h0400,3'b001, 3,2); check();
    tick(); idle(); stall = 1; fetch_ready = 1;
    push(0,0,0,0, 1,16'h1000,3'b001, 3,2); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h1000,3'b001, 3,2); check();
    // reset while a redirect is pending
    tick(); idle(); valid_in = 1; opcode = op_jmp; jmp_target = 16'h2000;
    push(0,1,0,0, 0,16'h1000,3'b001, 3,2); check();
    tick(); idle(); rst_n = 0;
    push(0,0,0,0, 1,16'h2000,3'b001, 3,2); check();
    tick(); idle();
    push(0,0,0,0, 0,16'h0000,3'b010, 0,0); check();
    // 16 never-taken BRs: 4-bit counter wraps to 0
    for (int i = 0; i < 16; i++) begin
      tick(); idle(); valid_in = 1; opcode = op_br; nzp = 3'b000;
      push(0,0,0,0, 0,16'h0000,3'b010, i,0); check();
    end
    tick(); idle();
    push(0,0,0,0, 0,16'h0000,3'b010, 16,0); check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL timeout at step %0d", step);
    $fatal(1, "timeout");
  end

endmodule
